// File: rtl/serial_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state encoding
// and the digit-counter width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes N = data_w/digit_w digit steps (minimum 1 bit).
    function automatic int cnt_width(input int data_w, input int digit_w);
        int n;
        int w;
        n = data_w / digit_w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGITWIDTH-bit ripple-carry digit adder.
// With SERIAL_ADDSUB_OVF_EN defined it also exports the carry into its top
// cell so the caller can derive two's-complement overflow.
module digit_adder #(
    parameter int DIGITWIDTH = 1
) (
    input  logic [DIGITWIDTH-1:0] a,
    input  logic [DIGITWIDTH-1:0] b,
    input  logic                  cin,
    output logic [DIGITWIDTH-1:0] sum,
    output logic                  cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic                  c_msb
`endif
);

    // carry[gi] is the carry into cell gi; carry[DIGITWIDTH] leaves the digit
    logic [DIGITWIDTH:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITWIDTH; gi = gi + 1) begin : g_cell
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
        end
    endgenerate

    assign cout = carry[DIGITWIDTH];

`ifdef SERIAL_ADDSUB_OVF_EN
    assign c_msb = carry[DIGITWIDTH-1];
`endif

endmodule

// File: rtl/serial_addsub.sv
// Handshaked digit-serial add/subtract unit. Processes DIGITWIDTH bits per
// clock, LSB digit first, through one shared digit_adder and a registered
// carry. Optional overflow output o_ovf is built when SERIAL_ADDSUB_OVF_EN
// is defined.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DIGITWIDTH = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATAWIDTH-1:0] i_a,
    input  logic [DATAWIDTH-1:0] i_b,
    input  logic                 i_sub,
    input  logic                 i_cin,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATAWIDTH-1:0] o_sum,
    output logic                 o_cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic                 o_ovf
`endif
);

    localparam int N  = DATAWIDTH / DIGITWIDTH;
    localparam int CW = cnt_width(DATAWIDTH, DIGITWIDTH);

    // A digit width that does not divide the operand width cannot be sequenced
    generate
        if ((DATAWIDTH % DIGITWIDTH) != 0) begin : g_bad_digitwidth
            $error("serial_addsub: DATAWIDTH must be a multiple of DIGITWIDTH");
        end
    endgenerate

    state_t                state_reg;
    logic                  ready_reg;
    logic                  valid_reg;
    logic [DATAWIDTH-1:0]  a_reg;
    logic [DATAWIDTH-1:0]  b_reg;
    logic                  sub_reg;
    logic                  carry_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATAWIDTH-1:0]  sum_reg;

    logic [DIGITWIDTH-1:0] b_digit;
    logic [DIGITWIDTH-1:0] digit_sum;
    logic                  digit_cout;
    logic [DATAWIDTH-1:0]  sum_shift;
    logic                  last_step;

    // Subtraction is A + ~B + ~borrow, so only B's digit is conditionally inverted
    assign b_digit   = sub_reg ? ~b_reg[DIGITWIDTH-1:0] : b_reg[DIGITWIDTH-1:0];
    assign last_step = (cnt_reg == CW'(N - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
    logic digit_c_msb;
    logic ovf_reg;

    digit_adder #(.DIGITWIDTH(DIGITWIDTH)) u_digit_adder (
        .a     (a_reg[DIGITWIDTH-1:0]),
        .b     (b_digit),
        .cin   (carry_reg),
        .sum   (digit_sum),
        .cout  (digit_cout),
        .c_msb (digit_c_msb)
    );

    // Overflow is taken from the final (most significant) digit only
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_step) begin
            ovf_reg <= digit_c_msb ^ digit_cout;
        end
    end

    assign o_ovf = ovf_reg;
`else
    digit_adder #(.DIGITWIDTH(DIGITWIDTH)) u_digit_adder (
        .a    (a_reg[DIGITWIDTH-1:0]),
        .b    (b_digit),
        .cin  (carry_reg),
        .sum  (digit_sum),
        .cout (digit_cout)
    );
`endif

    // New result digit enters at the MSB side; after N steps digit 0 sits at the bottom
    generate
        if (N == 1) begin : g_single_digit
            assign sum_shift = digit_sum;
        end else begin : g_multi_digit
            assign sum_shift = {digit_sum, sum_reg[DATAWIDTH-1:DIGITWIDTH]};
        end
    endgenerate

    // Control FSM plus datapath registers, with registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        a_reg     <= i_a;
                        b_reg     <= i_b;
                        sub_reg   <= i_sub;
                        carry_reg <= i_sub ? ~i_cin : i_cin;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGITWIDTH;
                    b_reg     <= b_reg >> DIGITWIDTH;
                    sum_reg   <= sum_shift;
                    carry_reg <= digit_cout;
                    if (last_step) begin
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_reg;
    assign o_valid = valid_reg;
    assign o_sum   = sum_reg;
    assign o_cout  = carry_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: table of directed add/sub vectors on
// a DIGITWIDTH=1 instance, plus hand-written backpressure, back-to-back
// handshake, asynchronous reset and DIGITWIDTH=4 sequences.
// Overflow checks are active when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;

    // DIGITWIDTH=1 instance
    logic       i_valid, o_ready, i_sub, i_cin, o_valid, i_ready, o_cout;
    logic [7:0] i_a, i_b, o_sum;
    logic       ovf;

    // DIGITWIDTH=4 instance
    logic       w_valid, w_ready_o, w_sub, w_cin, w_valid_o, w_ready_i, w_cout;
    logic [7:0] w_a, w_b, w_sum;
    logic       w_ovf;

    int n_vec;
    int n_miss;

    serial_addsub #(.DATAWIDTH(8), .DIGITWIDTH(1)) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .i_cin   (i_cin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    serial_addsub #(.DATAWIDTH(8), .DIGITWIDTH(4)) dut4 (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_valid (w_valid),
        .o_ready (w_ready_o),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_sub   (w_sub),
        .i_cin   (w_cin),
        .o_valid (w_valid_o),
        .i_ready (w_ready_i),
        .o_sum   (w_sum),
        .o_cout  (w_cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .o_ovf   (w_ovf)
`endif
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf   = 1'b0;
    assign w_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Accept one operation on the DIGITWIDTH=1 instance, scramble inputs, wait for o_valid
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic cin, output int lat);
        int guard;
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        i_a = a; i_b = b; i_sub = sub; i_cin = cin; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_a = ~a; i_b = ~b; i_sub = ~sub; i_cin = ~cin;
        check("ready_low_after_accept", {31'd0, o_ready}, 32'd0);
        lat = 0;
        while (!o_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Complete the result handshake and confirm return to IDLE
    task automatic handshake(input string tag);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_ready_rise"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int hi_cycles;

        n_vec  = 0;
        n_miss = 0;
        //            a      b      sub   cin   sum    cout  ovf
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h50, 8'h20, 1'b1, 1'b1, 8'h2F, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0; i_cin = 1'b0;
        w_valid = 1'b0; w_ready_i = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_sum",   {24'd0, o_sum},   32'd0);
        check("rst_cout",  {31'd0, o_cout},  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            $display("vec %0d: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, o_sum, o_cout, ovf, lat);
            check($sformatf("vec%0d_latency", i), lat,               32'd8);
            check($sformatf("vec%0d_sum", i),     {24'd0, o_sum},    {24'd0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i),    {31'd0, o_cout},   {31'd0, vecs[i].cout});
`ifdef SERIAL_ADDSUB_OVF_EN
            check($sformatf("vec%0d_ovf", i),     {31'd0, ovf},      {31'd0, vecs[i].ovf});
`endif
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: hold i_ready low 5 cycles, poke an ignored request
        run_op(8'h11, 8'h22, 1'b0, 1'b0, lat);
        $display("backpressure: sum=%h lat=%0d", o_sum, lat);
        check("bp_latency", lat, 32'd8);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                i_a = 8'hF0; i_b = 8'h0F; i_sub = 1'b1; i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            check($sformatf("bp_valid_c%0d", c), {31'd0, o_valid}, 32'd1);
            check($sformatf("bp_ready_c%0d", c), {31'd0, o_ready}, 32'd0);
            check($sformatf("bp_sum_c%0d", c),   {24'd0, o_sum},   32'h33);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        handshake("bp");
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_not_queued_valid", {31'd0, o_valid}, 32'd0);
            check("bp_not_queued_ready", {31'd0, o_ready}, 32'd1);
        end

        // i_ready already high when DONE is entered: o_valid lasts exactly one cycle
        i_ready = 1'b1;
        run_op(8'h03, 8'h04, 1'b0, 1'b0, lat);
        hi_cycles = 0;
        while (o_valid && hi_cycles < 20) begin
            hi_cycles++;
            @(posedge clk); #1;
        end
        i_ready = 1'b0;
        $display("early ready: valid high %0d cycles, sum=%h", hi_cycles, o_sum);
        check("early_ready_valid_width", hi_cycles, 32'd1);
        check("early_ready_sum", {24'd0, o_sum}, 32'h07);
        check("early_ready_idle", {31'd0, o_ready}, 32'd1);

        // Asynchronous reset during RUN step 3
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        handshake("pre_rst");
        i_a = 8'h5A; i_b = 8'h3C; i_sub = 1'b0; i_cin = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-run: ready=%0d valid=%0d sum=%h cout=%0d",
                 o_ready, o_valid, o_sum, o_cout);
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_sum",   {24'd0, o_sum},   32'd0);
        check("arst_cout",  {31'd0, o_cout},  32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("arst_ovf",   {31'd0, ovf},     32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_no_result", {31'd0, o_valid}, 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, lat);
        $display("after reset: 01+01 -> sum=%h lat=%0d", o_sum, lat);
        check("post_rst_sum", {24'd0, o_sum}, 32'h02);
        check("post_rst_latency", lat, 32'd8);
        handshake("post_rst");

        // DIGITWIDTH=4 instance: two-cycle latency
        w_a = 8'h5A; w_b = 8'h3C; w_sub = 1'b0; w_cin = 1'b0; w_valid = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0; w_a = 8'h00; w_b = 8'hFF;
        lat = 0;
        while (!w_valid_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("dw4: 5A+3C -> sum=%h cout=%0d ovf=%0d lat=%0d", w_sum, w_cout, w_ovf, lat);
        check("dw4_latency", lat, 32'd2);
        check("dw4_sum",  {24'd0, w_sum},  32'h96);
        check("dw4_cout", {31'd0, w_cout}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("dw4_ovf",  {31'd0, w_ovf},  32'd1);
`endif
        w_ready_i = 1'b1;
        @(posedge clk); #1;
        w_ready_i = 1'b0;
        check("dw4_ready_rise", {31'd0, w_ready_o}, 32'd1);
        check("dw4_valid_drop", {31'd0, w_valid_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
